// File: rtl/riscv_mem_arbiter.sv
// Unified memory-port arbiter for the 5-stage core. The IF stage and the MEM stage
// share one req/gnt/rvalid bus, with one transaction outstanding at a time. MEM has
// priority over IF. IF is forced through after STARVE_LIMIT consecutive losses.
// A winning fetch is presented on the bus as a full-word read (we=0, be=4'hF, wdata=0).
module riscv_mem_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_kill,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_stall,
  input  logic            mem_req,
  input  logic            mem_we,
  input  logic [3:0]      mem_be,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  output logic            mem_rvalid,
  output logic [XLEN-1:0] mem_rdata,
  output logic            mem_stall,
  output logic            bus_req,
  output logic            bus_we,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  state_t           state, state_nxt;
  logic             owner_mem;
  logic             killed;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved, if_wins, any_req, rsp;

  // Arbitration decision and response detection
  always_comb begin
    starved = (STARVE_LIMIT != 0) && (starve_cnt == CNT_MAX);
    if_wins = if_req && (!mem_req || starved);
    any_req = if_req || mem_req;
    rsp     = (state == WAIT_RSP) && bus_rvalid;
  end

  // Next-state logic for the single-transaction sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (any_req)    state_nxt = ISSUE;
      ISSUE:    if (bus_gnt)    state_nxt = WAIT_RSP;
      WAIT_RSP: if (bus_rvalid) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Response routing and stalls; a kill arriving with the response still suppresses it
  always_comb begin
    if_rvalid  = rsp && !owner_mem && !killed && !if_kill;
    mem_rvalid = rsp && owner_mem;
    if_rdata   = bus_rdata;
    mem_rdata  = bus_rdata;
    if_stall   = if_req && !if_rvalid;
    mem_stall  = mem_req && !mem_rvalid;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Bus request register, owner, kill flag and IF starvation counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_be     <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      owner_mem  <= 1'b0;
      killed     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            bus_req   <= 1'b1;
            owner_mem <= !if_wins;
            if (if_wins) begin
              bus_we    <= 1'b0;
              bus_be    <= '1;
              bus_addr  <= if_addr;
              bus_wdata <= '0;
            end else begin
              bus_we    <= mem_we;
              bus_be    <= mem_be;
              bus_addr  <= mem_addr;
              bus_wdata <= mem_wdata;
            end
          end
          if (if_req) begin
            if (if_wins)                   starve_cnt <= '0;
            else if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + CNT_W'(1);
          end
        end
        ISSUE: if (bus_gnt) bus_req <= 1'b0;
        default: ;
      endcase
      // Clearing on response doubles as "cleared on IDLE entry"
      if (rsp)
        killed <= 1'b0;
      else if ((state != IDLE) && !owner_mem && if_kill)
        killed <= 1'b1;
    end
  end

endmodule
